// File: rtl/md4_pkg.sv
// Shared MD4 definitions: round constants, shift and message-word tables,
// FSM state type and the standard initial chaining value.
package md4_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } md4_state_e;

  localparam logic [31:0] K_R1 = 32'h00000000;
  localparam logic [31:0] K_R2 = 32'h5A827999;
  localparam logic [31:0] K_R3 = 32'h6ED9EBA1;

  // Packing {D, C, B, A}, A in the low word.
  localparam logic [127:0] MD4_IV = {32'h10325476, 32'h98badcfe, 32'hefcdab89, 32'h67452301};

  localparam logic [4:0] S_R1 [4] = '{5'd3, 5'd7, 5'd11, 5'd19};
  localparam logic [4:0] S_R2 [4] = '{5'd3, 5'd5, 5'd9,  5'd13};
  localparam logic [4:0] S_R3 [4] = '{5'd3, 5'd9, 5'd11, 5'd15};

  localparam logic [3:0] IDX_R2 [16] = '{4'd0, 4'd4, 4'd8, 4'd12, 4'd1, 4'd5, 4'd9, 4'd13,
                                         4'd2, 4'd6, 4'd10, 4'd14, 4'd3, 4'd7, 4'd11, 4'd15};
  localparam logic [3:0] IDX_R3 [16] = '{4'd0, 4'd8, 4'd4, 4'd12, 4'd2, 4'd10, 4'd6, 4'd14,
                                         4'd1, 4'd9, 4'd5, 4'd13, 4'd3, 4'd11, 4'd7, 4'd15};

  typedef struct packed {
    logic [1:0]  rnd;
    logic [3:0]  widx;
    logic [4:0]  shamt;
    logic [31:0] kconst;
  } step_cfg_t;

  // Per-step selection of round function, message word, rotation and constant.
  function automatic step_cfg_t step_cfg(input logic [5:0] step);
    step_cfg_t cfg;
    cfg.rnd = step[5:4];
    case (step[5:4])
      2'd0: begin
        cfg.widx   = step[3:0];
        cfg.shamt  = S_R1[step[1:0]];
        cfg.kconst = K_R1;
      end
      2'd1: begin
        cfg.widx   = IDX_R2[step[3:0]];
        cfg.shamt  = S_R2[step[1:0]];
        cfg.kconst = K_R2;
      end
      2'd2: begin
        cfg.widx   = IDX_R3[step[3:0]];
        cfg.shamt  = S_R3[step[1:0]];
        cfg.kconst = K_R3;
      end
      default: begin
        cfg.widx   = 4'd0;
        cfg.shamt  = 5'd0;
        cfg.kconst = 32'h00000000;
      end
    endcase
    return cfg;
  endfunction

endpackage

// File: rtl/md4_step.sv
// One combinational MD4 step: returns (A + f(B,C,D) + X + K) rotated left by s.
module md4_step
  import md4_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] c_i,
  input  logic [31:0] d_i,
  input  logic [31:0] x_i,
  input  logic [31:0] k_i,
  input  logic [4:0]  s_i,
  input  logic [1:0]  rnd_i,
  output logic [31:0] new_o
);

  logic [31:0] f_s;
  logic [31:0] sum_s;

  // Round-dependent boolean function, then add and rotate
  always_comb begin
    f_s = 32'h00000000;
    case (rnd_i)
      2'd0:    f_s = (b_i & c_i) | (~b_i & d_i);
      2'd1:    f_s = (b_i & c_i) | (b_i & d_i) | (c_i & d_i);
      2'd2:    f_s = b_i ^ c_i ^ d_i;
      default: f_s = 32'h00000000;
    endcase
    sum_s = a_i + f_s + x_i + k_i;
    new_o = (sum_s << s_i) | (sum_s >> (6'd32 - {1'b0, s_i}));
  end

endmodule

// File: rtl/md4_round_engine.sv
// Iterative MD4 compression engine running UNROLL chained steps per clock.
// Define MD4_FEEDFORWARD_EN to add the input chaining value to the result.
module md4_round_engine
  import md4_pkg::*;
#(
  parameter int NUM_ROUNDS = 3,
  parameter int UNROLL     = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] state_in,
  input  logic [511:0] msg_in,
  output logic         busy,
  output logic         done,
  output logic [127:0] state_out
);

  localparam int         TOTAL_STEPS = 16 * NUM_ROUNDS;
  localparam logic [5:0] LAST_BASE   = 6'(TOTAL_STEPS - UNROLL);
  localparam logic [5:0] STEP_INC    = 6'(UNROLL);

  md4_state_e   state_q, state_d;
  logic [5:0]   step_q, step_d;
  logic [127:0] abcd_q, abcd_d;
  logic [511:0] msg_q, msg_d;
  logic [127:0] out_q, out_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         accept_s;
  logic [127:0] result_s;
  logic [127:0] chain_s [UNROLL+1];

  assign chain_s[0] = abcd_q;

  for (genvar j = 0; j < UNROLL; j++) begin : g_step
    step_cfg_t   cfg_s;
    logic [31:0] new_s;

    assign cfg_s = step_cfg(step_q + 6'(j));

    md4_step u_step (
      .a_i   (chain_s[j][31:0]),
      .b_i   (chain_s[j][63:32]),
      .c_i   (chain_s[j][95:64]),
      .d_i   (chain_s[j][127:96]),
      .x_i   (msg_q[{cfg_s.widx, 5'd0} +: 32]),
      .k_i   (cfg_s.kconst),
      .s_i   (cfg_s.shamt),
      .rnd_i (cfg_s.rnd),
      .new_o (new_s)
    );

    // (A,B,C,D) <= (D,new,B,C)
    assign chain_s[j+1] = {chain_s[j][95:64], chain_s[j][63:32], new_s, chain_s[j][127:96]};
  end

  // done is still high in the first IDLE cycle, so a start there is dropped
  assign accept_s = (state_q == ST_IDLE) && start && !done_q;

`ifdef MD4_FEEDFORWARD_EN
  logic [127:0] iv_q;

  // Chaining value captured at acceptance for the final word-wise addition
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iv_q <= 128'd0;
    end else if (accept_s) begin
      iv_q <= state_in;
    end else begin
      iv_q <= iv_q;
    end
  end

  assign result_s = {abcd_q[127:96] + iv_q[127:96], abcd_q[95:64] + iv_q[95:64],
                     abcd_q[63:32]  + iv_q[63:32],  abcd_q[31:0]  + iv_q[31:0]};
`else
  assign result_s = abcd_q;
`endif

  // Next-state logic for the IDLE/RUN/FINISH sequencer and datapath
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    abcd_d  = abcd_q;
    msg_d   = msg_q;
    out_d   = out_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          abcd_d  = state_in;
          msg_d   = msg_in;
          step_d  = 6'd0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        abcd_d = chain_s[UNROLL];
        if (step_q == LAST_BASE) begin
          step_d  = 6'd0;
          state_d = ST_FINISH;
        end else begin
          step_d  = step_q + STEP_INC;
          state_d = ST_RUN;
        end
      end
      ST_FINISH: begin
        out_d   = result_s;
        state_d = ST_IDLE;
      end
      default: begin
        step_d  = 6'd0;
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_q == ST_FINISH);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      step_q  <= 6'd0;
      abcd_q  <= 128'd0;
      msg_q   <= 512'd0;
      out_q   <= 128'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      abcd_q  <= abcd_d;
      msg_q   <= msg_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign state_out = out_q;

endmodule

// File: tb/tb_md4_round_engine.sv
// Self-checking bench: four engine configurations driven in parallel and
// compared with golden digests and a loop-based MD4 reference model.
module tb_md4_round_engine;

  localparam logic [127:0] TB_IV = {32'h10325476, 32'h98badcfe, 32'hefcdab89, 32'h67452301};

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [127:0] state_in;
  logic [511:0] msg_in;
  logic         busy_w [4];
  logic         done_w [4];
  logic [127:0] out_w  [4];

  int checks = 0;
  int errors = 0;

  int           exp_lat   [4] = '{49, 25, 13, 17};
  int           rounds_of [4] = '{3, 3, 3, 1};
  int           lat       [4];
  int           pulses    [4];
  logic [127:0] res       [4];

  typedef struct {
    logic [127:0] iv;
    logic [511:0] msg;
    logic [127:0] digest;
  } vec_t;
  vec_t vecs [2];

  always #5 clk = ~clk;

  md4_round_engine #(.NUM_ROUNDS(3), .UNROLL(1)) u_r3u1 (.clk(clk), .rst_n(rst_n), .start(start),
    .state_in(state_in), .msg_in(msg_in), .busy(busy_w[0]), .done(done_w[0]), .state_out(out_w[0]));
  md4_round_engine #(.NUM_ROUNDS(3), .UNROLL(2)) u_r3u2 (.clk(clk), .rst_n(rst_n), .start(start),
    .state_in(state_in), .msg_in(msg_in), .busy(busy_w[1]), .done(done_w[1]), .state_out(out_w[1]));
  md4_round_engine #(.NUM_ROUNDS(3), .UNROLL(4)) u_r3u4 (.clk(clk), .rst_n(rst_n), .start(start),
    .state_in(state_in), .msg_in(msg_in), .busy(busy_w[2]), .done(done_w[2]), .state_out(out_w[2]));
  md4_round_engine #(.NUM_ROUNDS(1), .UNROLL(1)) u_r1u1 (.clk(clk), .rst_n(rst_n), .start(start),
    .state_in(state_in), .msg_in(msg_in), .busy(busy_w[3]), .done(done_w[3]), .state_out(out_w[3]));

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] md4_model(input logic [127:0] iv, input logic [511:0] msg,
                                             input int rounds);
    logic [31:0] a, b, c, d, f, kc, t, nw, x;
    int idx, sh, i, r;
    int s_tab [3][4] = '{'{3, 7, 11, 19}, '{3, 5, 9, 13}, '{3, 9, 11, 15}};
    int r3_ord [16]  = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
    a = iv[31:0]; b = iv[63:32]; c = iv[95:64]; d = iv[127:96];
    for (int st = 0; st < 16 * rounds; st++) begin
      r = st / 16;
      i = st % 16;
      if (r == 0) begin
        f = (b & c) | (~b & d); kc = 32'h00000000; idx = i;
      end else if (r == 1) begin
        f = (b & c) | (b & d) | (c & d); kc = 32'h5A827999; idx = (i % 4) * 4 + i / 4;
      end else begin
        f = b ^ c ^ d; kc = 32'h6ED9EBA1; idx = r3_ord[i];
      end
      sh = s_tab[r][i % 4];
      x  = msg[32 * idx +: 32];
      t  = a + f + x + kc;
      nw = (t << sh) | (t >> (32 - sh));
      a = d; d = c; c = b; b = nw;
    end
`ifdef MD4_FEEDFORWARD_EN
    a = a + iv[31:0]; b = b + iv[63:32]; c = c + iv[95:64]; d = d + iv[127:96];
`endif
    return {d, c, b, a};
  endfunction

  // Golden digests include feedforward; without it the expected output is digest - iv.
  function automatic logic [127:0] from_digest(input logic [127:0] dg, input logic [127:0] iv);
`ifdef MD4_FEEDFORWARD_EN
    return dg;
`else
    return {dg[127:96] - iv[127:96], dg[95:64] - iv[95:64], dg[63:32] - iv[63:32], dg[31:0] - iv[31:0]};
`endif
  endfunction

  function automatic logic [511:0] rand_msg();
    logic [511:0] m;
    for (int w = 0; w < 16; w++) m[32 * w +: 32] = $urandom;
    return m;
  endfunction

  // Must be entered at a negedge; start is sampled by the following posedge.
  task automatic run_block(input logic [127:0] iv, input logic [511:0] msg, input bit restart,
                           input bit scramble, input bit start_on_done);
    state_in = iv;
    msg_in   = msg;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (scramble) begin
      state_in = {$urandom, $urandom, $urandom, $urandom};
      msg_in   = rand_msg();
    end
    for (int k = 0; k < 4; k++) begin
      lat[k] = 0; pulses[k] = 0; res[k] = 128'd0;
    end
    for (int c = 1; c <= 90; c++) begin
      @(negedge clk);
      if (start_on_done && c == exp_lat[0] + 1) begin
        chk("busy_after_start_in_done_cycle", 128'(busy_w[0]), 128'd0);
        chk("done_after_start_in_done_cycle", 128'(done_w[0]), 128'd0);
        start = 1'b0;
      end
      for (int k = 0; k < 4; k++) begin
        if (done_w[k]) begin
          pulses[k]++;
          if (lat[k] == 0) begin
            lat[k] = c;
            res[k] = out_w[k];
          end
        end
      end
      if (restart && c == 5) start = 1'b1;
      if (restart && c == 6) start = 1'b0;
      if (start_on_done && c == exp_lat[0]) start = 1'b1;
    end
  endtask

  task automatic check_block(input string nm, input logic [127:0] iv, input logic [511:0] msg,
                             input logic [127:0] exp3, input bit chk_pulses);
    logic [127:0] e;
    for (int k = 0; k < 4; k++) begin
      e = (rounds_of[k] == 3) ? exp3 : md4_model(iv, msg, 1);
      chk($sformatf("%s_state_out[%0d]", nm, k), res[k], e);
      chk($sformatf("%s_latency[%0d]", nm, k), 128'(lat[k]), 128'(exp_lat[k]));
      if (chk_pulses) chk($sformatf("%s_done_pulses[%0d]", nm, k), 128'(pulses[k]), 128'd1);
    end
  endtask

  initial begin
    logic [127:0] iv;
    logic [511:0] msg;

    vecs[0].iv = TB_IV; vecs[0].msg = 512'd0;
    vecs[0].msg[31:0] = 32'h00000080;
    vecs[0].digest = {32'hc089c0e0, 32'hd7593cb7, 32'h31e96ad1, 32'he0cfd631};
    vecs[1].iv = TB_IV; vecs[1].msg = 512'd0;
    vecs[1].msg[31:0] = 32'h80636261;
    vecs[1].msg[479:448] = 32'h00000018;
    vecs[1].digest = {32'h9d72a67a, 32'he80ac15f, 32'h52d821af, 32'h7a0148a4};

    rst_n = 1'b0; start = 1'b0; state_in = 128'd0; msg_in = 512'd0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("reset_busy[%0d]", k), 128'(busy_w[k]), 128'd0);
      chk($sformatf("reset_done[%0d]", k), 128'(done_w[k]), 128'd0);
      chk($sformatf("reset_out[%0d]", k), out_w[k], 128'd0);
    end
    rst_n = 1'b1;

    // Golden vectors; the first start coincides with the first edge out of reset
    for (int v = 0; v < 2; v++) begin
      run_block(vecs[v].iv, vecs[v].msg, 1'b0, 1'b0, 1'b0);
      check_block($sformatf("golden%0d", v), vecs[v].iv, vecs[v].msg,
                  from_digest(vecs[v].digest, vecs[v].iv), 1'b1);
      for (int k = 0; k < 4; k++)
        chk($sformatf("hold_after_golden%0d[%0d]", v, k), out_w[k], res[k]);
    end

    for (int n = 0; n < 5; n++) begin
      iv  = {$urandom, $urandom, $urandom, $urandom};
      msg = rand_msg();
      run_block(iv, msg, 1'b0, n[0], 1'b0);
      check_block($sformatf("random%0d", n), iv, msg, md4_model(iv, msg, 3), 1'b1);
    end

    run_block(TB_IV, vecs[0].msg, 1'b1, 1'b1, 1'b0);
    check_block("restart_ignored", TB_IV, vecs[0].msg, from_digest(vecs[0].digest, TB_IV), 1'b1);

    iv  = {$urandom, $urandom, $urandom, $urandom};
    msg = rand_msg();
    run_block(iv, msg, 1'b0, 1'b0, 1'b1);
    chk("start_on_done_result", res[0], md4_model(iv, msg, 3));
    chk("start_on_done_pulses", 128'(pulses[0]), 128'd1);
    chk("start_on_done_hold", out_w[0], md4_model(iv, msg, 3));

    // Abort mid-run with reset, then a fresh block straight out of reset
    state_in = {$urandom, $urandom, $urandom, $urandom};
    msg_in   = rand_msg();
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("midrun_reset_busy[%0d]", k), 128'(busy_w[k]), 128'd0);
      chk($sformatf("midrun_reset_done[%0d]", k), 128'(done_w[k]), 128'd0);
      chk($sformatf("midrun_reset_out[%0d]", k), out_w[k], 128'd0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    iv  = {$urandom, $urandom, $urandom, $urandom};
    msg = rand_msg();
    run_block(iv, msg, 1'b0, 1'b0, 1'b0);
    check_block("after_abort", iv, msg, md4_model(iv, msg, 3), 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/md4_round_engine.md
MD4_ROUND_ENGINE -- requirements
Module: md4_round_engine

Interface
REQ-001 Parameter NUM_ROUNDS, default 3, number of MD4 rounds executed; legal values 1, 2, 3.
REQ-002 Parameter UNROLL, default 1, MD4 steps evaluated per clock; legal values 1, 2, 4.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 state_in  input  128  chaining value; [31:0]=A, [63:32]=B, [95:64]=C, [127:96]=D.
REQ-007 msg_in  input  512  message block; word X[k] = msg_in[32k+31:32k], k=0..15.
REQ-008 busy  output  1  high while a block is being processed.
REQ-009 done  output  1  one-cycle pulse when state_out becomes valid.
REQ-010 state_out  output  128  result, same packing as state_in.

Function
REQ-011 The FSM SHALL have states IDLE, RUN and FINISH.
REQ-012 IDLE with start=1 SHALL register state_in and msg_in, clear the step counter and enter RUN next cycle; otherwise it stays in IDLE.
REQ-013 In RUN, each cycle SHALL perform UNROLL consecutive steps: new = (A + f(B,C,D) + X[k] + K) <<< s, then (A,B,C,D) <= (D,new,B,C), all mod 2^32.
REQ-014 Round 1 (steps 0-15) SHALL use f=(B&C)|(~B&D), K=0, k=step, s cycling 3,7,11,19.
REQ-015 Round 2 (steps 16-31) SHALL use f=(B&C)|(B&D)|(C&D), K=32'h5A827999, k order 0,4,8,12,1,5,9,13,2,6,10,14,3,7,11,15, s cycling 3,5,9,13.
REQ-016 Round 3 (steps 32-47) SHALL use f=B^C^D, K=32'h6ED9EBA1, k order 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15, s cycling 3,9,11,15.
REQ-017 RUN SHALL last exactly 16*NUM_ROUNDS/UNROLL cycles, then the FSM SHALL enter FINISH.
REQ-018 FINISH SHALL last one cycle: state_out loaded, done=1; the FSM then returns to IDLE.
REQ-019 busy SHALL be 1 in RUN and FINISH, 0 in IDLE.
REQ-020 Latency from the start-sampling edge to the done-high edge SHALL be 16*NUM_ROUNDS/UNROLL+1 cycles.
REQ-021 start while busy=1 SHALL be ignored, with no queuing.
REQ-022 state_out SHALL hold its value until the next FINISH; start=1 in the same cycle done=1 SHALL be ignored.
REQ-023 Changes on state_in/msg_in after start is sampled SHALL NOT affect the result.

Reset
REQ-024 rst_n=0 SHALL immediately force IDLE, busy=0, done=0, state_out=0 and the step counter to 0, including mid-RUN (the block is aborted).
REQ-025 The first start SHALL be accepted on the first rising edge with rst_n=1.

Configuration
REQ-026 With macro MD4_FEEDFORWARD_EN defined, state_out SHALL be the word-wise mod-2^32 sum of the registered state_in and the final (A,B,C,D).
REQ-027 Without MD4_FEEDFORWARD_EN, state_out SHALL be the final (A,B,C,D) only; no adders are instantiated for feedforward.

Structure
REQ-028 Package md4_pkg SHALL hold the round constants, shift tables, word-index tables, the FSM state typedef and the default chaining value 67452301/efcdab89/98badcfe/10325476.
REQ-029 Sub-module md4_step (combinational single step: inputs A,B,C,D,X,K,s,round select; output new word) SHALL be instantiated UNROLL times in a chain.

Verification
REQ-030 Default chaining value; msg word0=32'h00000080, all other words 0; feedforward on, NUM_ROUNDS=3 -> state_out A=e0cfd631, B=31e96ad1, C=d7593cb7, D=c089c0e0 (MD4("")).
REQ-031 Same flow with word0=32'h80636261, word14=32'h00000018 -> A=7a0148a4, B=52d821af, C=e80ac15f, D=9d72a67a (MD4("abc")).
REQ-032 UNROLL=1/2/4 runs of REQ-030 -> identical state_out; done exactly 49/25/13 cycles after start is sampled.
REQ-033 Pulse start again 5 cycles into RUN -> ignored; a single done pulse; result unchanged.
REQ-034 Assert rst_n low mid-RUN, then start a new block -> outputs zero during reset; the new result matches the golden model with no residue from the aborted block.
REQ-035 NUM_ROUNDS=1, feedforward off, zero message, default chaining value -> state_out equals a software model of 16 round-1 steps; done after 17 cycles.
